router_nport: RTL
=================

// Module: router_nport
// PURPOSE
//  Parametrised 1-to-N packet router, successor of the 3-port router. One byte-stream
//  input is routed by header address into one of NUM_PORTS output FIFOs.
//  Adds over the 3-port version: parametrised port count, width and depth;
//  invalid-address drop; per-port read timeout with FIFO flush.
//  Sits between the packet source (driver) and NUM_PORTS independent readers.
// PARAMETERS
//  NUM_PORTS   3    output channels (2..16); ADDR_W = $clog2(NUM_PORTS), min 1
//  DATA_W      8    beat width; header = {len[DATA_W-1:ADDR_W], addr[ADDR_W-1:0]}
//  FIFO_DEPTH  16   entries per output FIFO, power of 2
//  TIMEOUT     30   cycles vld_out[i]=1 with rd_en[i]=0 before port i is flushed
// PORTS
//  clk        in   1                    single clock, rising edge
//  rst        in   1                    asynchronous, active-low reset
//  data       in   DATA_W               input beat
//  pkt_valid  in   1                    beat on data is valid
//  busy       out  1                    beat not accepted this cycle; source holds data
//  rd_en      in   NUM_PORTS            pop request per port
//  vld_out    out  NUM_PORTS            port FIFO non-empty
//  dout       out  [NUM_PORTS][DATA_W]  FWFT head of each FIFO; 0 when empty
//  err        out  1                    1-cycle pulse: parity mismatch, bad address or len=0
//  flush      out  NUM_PORTS            1-cycle pulse: port i flushed by timeout
// BEHAVIOUR
//  - Reset (rst=0, async): FSM=IDLE; pointers, counters, parity accumulator = 0;
//    busy=0, err=0, flush=0, vld_out=0, dout=0. Effective immediately.
//  - Beat accepted iff pkt_valid && !busy. Packet = header, len payload, parity
//    (len+2 beats). Parity = XOR of header and all payload beats.
//  - FSM states:
//    IDLE: on an accepted beat, decode header.
//      - addr<NUM_PORTS && len!=0: write to FIFO[addr], latch dest -> PAYLOAD.
//      - otherwise: pulse err next cycle -> DROP.
//    PAYLOAD: write each beat, decrement remaining count -> PARITY after last beat.
//    PARITY: write parity beat; compare. Mismatch -> err=1 next cycle. -> IDLE.
//    DROP: discard beats until pkt_valid=0 for a cycle -> IDLE. No FIFO writes.
//  - busy=1 while FSM in PAYLOAD/PARITY or header-decode and FIFO[dest] full.
//    - busy is computed from the full flag at the start of the cycle; a same-cycle
//      pop does not release it.
//    - busy=0 in IDLE while header target unknown.
//    - A header to a full FIFO is held (busy=1) until space.
//  - Write latency: beat accepted at cycle t is visible on vld_out/dout at t+1.
//  - rd_en[i] with vld_out[i]=1 pops at the edge; dout[i] shows the next entry at t+1.
//  - rd_en[i] on an empty FIFO is ignored.
//  - FIFO counters use ptr width $clog2(FIFO_DEPTH)+1; full/empty from MSB compare.
//    Wrap-around is natural.
//  - Timeout counter per port:
//    - Counts while vld_out=1 && rd_en=0; clears on a pop or when empty.
//    - At count==TIMEOUT-1: clear the FIFO, pulse flush[i], clear the counter.
//    - If FSM is writing to port i: FSM -> DROP for the remainder of that packet.
//  - Flush and write to the same port in the same cycle: flush wins, write discarded.
//  - pkt_valid falling in PAYLOAD: stall (no timeout on input side).
// STRUCTURE
//  - router_pkg holds:
//    - state_e {IDLE, PAYLOAD, PARITY, DROP}
//    - hdr_addr()/hdr_len() functions
//    - ADDR_W derivation.
//  - Sub-module router_fifo (DATA_W, FIFO_DEPTH, TIMEOUT): FWFT FIFO + timeout counter.
//    router_nport generates NUM_PORTS instances; FSM and parity checker are top-level.
// TESTING (NUM_PORTS=3, DATA_W=8, FIFO_DEPTH=16, TIMEOUT=30)
//  - Send 0D,11,22,33, parity 0D to port 1 -> vld_out=3'b010 one cycle after header;
//    rd_en[1] yields dout 0D,11,22,33,0D; err stays 0.
//  - Same packet with parity FF -> 5 beats stored, err=1 for exactly 1 cycle
//    after the parity beat.
//  - Header 07 (addr 3, len 1) + 2 beats -> err pulse, no vld_out, FSM back to IDLE;
//    the next good packet routes correctly.
//  - 20-beat packet to port 0, no reads -> busy=1 after 16 stored; rd_en[0] for
//    4 cycles -> busy drops, all 20 beats read in order.
//  - Store 1 packet on port 2, hold rd_en=0 -> flush[2] pulses 30 cycles after
//    vld_out[2] rose; vld_out[2]=0 next cycle.
//  - Pull rst low mid-PAYLOAD -> all outputs 0 immediately; after release, a fresh
//    header is accepted as a new packet.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and helpers for the N-port packet router.
// Holds the FSM state type, the address-width derivation and the header field
// extractors used by router_nport.
package router_pkg;

    // Widest beat the header helpers support.
    localparam int unsigned MaxDataW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StParity,
        StDrop
    } state_e;

    // Address field width: ceil(log2(num_ports)), never below one bit.
    function automatic int unsigned addr_width(input int unsigned num_ports);
        return (num_ports < 2) ? 1 : unsigned'($clog2(num_ports));
    endfunction

    // Header = {len, addr}; addr occupies the low addr_w bits.
    function automatic logic [MaxDataW-1:0] hdr_addr(input logic [MaxDataW-1:0] hdr,
                                                     input int unsigned addr_w);
        logic [MaxDataW-1:0] mask;
        mask = (MaxDataW'(1) << addr_w) - MaxDataW'(1);
        return hdr & mask;
    endfunction

    function automatic logic [MaxDataW-1:0] hdr_len(input logic [MaxDataW-1:0] hdr,
                                                    input int unsigned addr_w);
        return hdr >> addr_w;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// One output channel of the router: first-word-fall-through FIFO plus a read
// timeout that flushes the FIFO when the reader ignores it too long.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   wr_en_i         write request (ignored when full or during a flush)
//   wr_data_i       beat to store
//   rd_en_i         pop request (ignored when empty)
//   vld_o           FIFO non-empty
//   full_o          FIFO full
//   dout_o          head entry, 0 when empty
//   flush_o         1-cycle pulse: timeout expired, FIFO cleared at this edge
module router_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 30
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic              vld_o,
    output logic              full_o,
    output logic [DATA_W-1:0] dout_o,
    output logic              flush_o
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

    logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              empty, push, pop, stall;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty  = (wptr_q == rptr_q);
    assign full_o = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                    (wptr_q[PtrW-2:0] == rptr_q[PtrW-2:0]);
    assign vld_o  = !empty;
    assign dout_o = empty ? '0 : mem_q[rptr_q[PtrW-2:0]];

    assign stall   = vld_o && !rd_en_i;
    assign flush_o = stall && (cnt_q == CntW'(TIMEOUT - 1));
    assign pop     = rd_en_i && vld_o;
    // A flush in the same cycle wins over a write.
    assign push    = wr_en_i && !full_o && !flush_o;

    always_comb begin
        wptr_d = wptr_q + PtrW'(push);
        rptr_d = rptr_q + PtrW'(pop);
        cnt_d  = stall ? cnt_q + CntW'(1) : '0;
        if (flush_o) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[PtrW-2:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/router_nport.sv
// 1-to-N packet router. A byte stream of packets {header, len payload beats,
// parity} is steered by the header address into one of NUM_PORTS output FIFOs.
// Bad headers (address out of range, len 0) are dropped with an err pulse;
// parity mismatches are stored but flagged with an err pulse.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   data_i          input beat;  pkt_valid_i  beat valid
//   busy_o          beat not accepted this cycle, source must hold it
//   rd_en_i         per-port pop request
//   vld_out_o       per-port FIFO non-empty
//   dout_o          per-port FIFO head, port i at [i*DATA_W +: DATA_W]
//   err_o           1-cycle pulse: parity mismatch or dropped header
//   flush_o         per-port 1-cycle pulse: FIFO flushed by read timeout
module router_nport
    import router_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 30
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        pkt_valid_i,
    output logic                        busy_o,
    input  logic [NUM_PORTS-1:0]        rd_en_i,
    output logic [NUM_PORTS-1:0]        vld_out_o,
    output logic [NUM_PORTS*DATA_W-1:0] dout_o,
    output logic                        err_o,
    output logic [NUM_PORTS-1:0]        flush_o
);
    localparam int unsigned AddrW = addr_width(NUM_PORTS);
    localparam int unsigned LenW  = DATA_W - AddrW;

    state_e              state_q, state_d;
    logic [AddrW-1:0]    dest_q, dest_d;
    logic [LenW-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   par_q, par_d;
    logic                err_q, err_d;

    logic [MaxDataW-1:0] hdr_wide;
    logic [AddrW-1:0]    hdr_a;
    logic [LenW-1:0]     hdr_l;
    logic                hdr_ok, in_pkt, accept, wr_go;
    logic [AddrW-1:0]    wr_port;
    logic [NUM_PORTS-1:0] full, wr_en;

    assign hdr_wide = MaxDataW'(data_i);
    assign hdr_a    = AddrW'(hdr_addr(hdr_wide, AddrW));
    assign hdr_l    = LenW'(hdr_len(hdr_wide, AddrW));
    assign hdr_ok   = (32'(hdr_a) < NUM_PORTS) && (hdr_l != '0);

    assign in_pkt = (state_q == StPayload) || (state_q == StParity);
    // Full flag is taken from the start of the cycle; a same-cycle pop does not help.
    assign busy_o = in_pkt ? full[dest_q]
                           : (state_q == StIdle) && pkt_valid_i && hdr_ok && full[hdr_a];
    assign accept  = pkt_valid_i && !busy_o;
    assign wr_go   = accept && (in_pkt || ((state_q == StIdle) && hdr_ok));
    assign wr_port = in_pkt ? dest_q : hdr_a;
    assign err_o   = err_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            dest_q  <= '0;
            rem_q   <= '0;
            par_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            rem_q   <= rem_d;
            par_q   <= par_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        rem_d   = rem_q;
        par_d   = par_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (hdr_ok) begin
                        dest_d  = hdr_a;
                        rem_d   = hdr_l;
                        par_d   = data_i;
                        state_d = StPayload;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDrop;
                    end
                end
            end
            StPayload: begin
                if (accept) begin
                    par_d = par_q ^ data_i;
                    rem_d = rem_q - LenW'(1);
                    if (rem_q == LenW'(1)) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (accept) begin
                    err_d   = (data_i != par_q);
                    state_d = StIdle;
                end
            end
            StDrop: begin
                if (!pkt_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // The destination was flushed under us: abandon the rest of this packet.
        if ((in_pkt || wr_go) && flush_o[wr_port]) begin
            state_d = StDrop;
        end
    end

    // Output logic: per-port write strobes
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            wr_en[i] = wr_go && (wr_port == AddrW'(i));
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        router_fifo #(
            .DATA_W    (DATA_W),
            .FIFO_DEPTH(FIFO_DEPTH),
            .TIMEOUT   (TIMEOUT)
        ) u_fifo (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .wr_en_i  (wr_en[i]),
            .wr_data_i(data_i),
            .rd_en_i  (rd_en_i[i]),
            .vld_o    (vld_out_o[i]),
            .full_o   (full[i]),
            .dout_o   (dout_o[i*DATA_W +: DATA_W]),
            .flush_o  (flush_o[i])
        );
    end

endmodule
